// File: rtl/rej_uniform_sampler.sv
// Rejection sampler for matrix A expansion: scans squeezed SHAKE128 bytes three at a time
// and keeps 23-bit candidates below Q as polynomial coefficients.
module rej_uniform_sampler #(
    parameter int unsigned BUFLEN_BYTES = 842,
    parameter int unsigned N            = 256,
    parameter int unsigned Q            = 8380417
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rtr,
    input  logic [8*BUFLEN_BYTES-1:0] linear_buf_in,
    input  logic [15:0]               buflen,
    input  logic [8:0]                ctr_in,
    output logic [32*N-1:0]           linear_coeffs_out,
    output logic [8:0]                ctr_out,
    output logic                      rts
);
    localparam int unsigned BIDX_W  = $clog2(BUFLEN_BYTES);
    localparam int unsigned CIDX_W  = $clog2(N);
    localparam logic [15:0] LEN_MAX = 16'(BUFLEN_BYTES);
    localparam logic [8:0]  CTR_MAX = 9'(N);
    localparam logic [22:0] Q_VAL   = 23'(Q);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  in_bytes [BUFLEN_BYTES];
    logic [7:0]  buf_q    [BUFLEN_BYTES];
    logic [7:0]  buf_d    [BUFLEN_BYTES];
    logic [22:0] coeff_q  [N];
    logic [22:0] coeff_d  [N];
    logic [15:0] len_q, len_d;
    logic [15:0] pos_q, pos_d;
    logic [8:0]  ctr_q, ctr_d;
    logic        rts_q, rts_d;

    logic [BIDX_W-1:0] idx0, idx1, idx2;
    logic [22:0]       cand;
    logic              scan_end;

    for (genvar i = 0; i < BUFLEN_BYTES; i++) begin : g_in_bytes
        assign in_bytes[i] = linear_buf_in[8*i +: 8];
    end

    for (genvar j = 0; j < N; j++) begin : g_coeff_out
        assign linear_coeffs_out[32*j +: 32] = {9'd0, coeff_q[j]};
    end

    assign idx0 = pos_q[BIDX_W-1:0];
    assign idx1 = BIDX_W'(pos_q + 16'd1);
    assign idx2 = BIDX_W'(pos_q + 16'd2);

    // Top bit of the third byte never takes part in the candidate.
    assign cand     = {buf_q[idx2][6:0], buf_q[idx1], buf_q[idx0]};
    assign scan_end = (ctr_q == CTR_MAX) || (({1'b0, pos_q} + 17'd3) > {1'b0, len_q});

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        coeff_d = coeff_q;
        len_d   = len_q;
        pos_d   = pos_q;
        ctr_d   = ctr_q;
        rts_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rtr) begin
                    buf_d   = in_bytes;
                    len_d   = (buflen > LEN_MAX) ? LEN_MAX : buflen;
                    ctr_d   = (ctr_in > CTR_MAX) ? CTR_MAX : ctr_in;
                    pos_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (scan_end) begin
                    state_d = StDone;
                    rts_d   = 1'b1;
                end else begin
                    if (cand < Q_VAL) begin
                        coeff_d[ctr_q[CIDX_W-1:0]] = cand;
                        ctr_d = ctr_q + 9'd1;
                    end
                    pos_d = pos_q + 16'd3;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            coeff_q <= '{default: '0};
            len_q   <= '0;
            pos_q   <= '0;
            ctr_q   <= '0;
            rts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            coeff_q <= coeff_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            ctr_q   <= ctr_d;
            rts_q   <= rts_d;
        end
    end

    // Capture buffer only matters after a capture, so it needs no reset.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign ctr_out = ctr_q;
    assign rts     = rts_q;

endmodule

// File: doc/rej_uniform_sampler.md
Name: rej_uniform_sampler

Overview:
- Downstream consumer of the SHAKE128 squeeze stage in the poly_uniform path (matrix A expansion).
- Takes the squeezed byte buffer, scans it 3 bytes per cycle, and turns each triple into a 23-bit candidate.
- Keeps candidates below Q as polynomial coefficients and reports how many coefficients are filled.
- Coefficients already stored below the start index are preserved, so the controller can squeeze another block and call again to refill.

Parameters:
- BUFLEN_BYTES, 842, capacity of the input byte buffer (matches the 6736-bit squeeze output).
- N, 256, coefficients per polynomial.
- Q, 8380417, modulus; a candidate is accepted when it is strictly below Q.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- rtr  input  1  start request; sampled only in IDLE.
- linear_buf_in  input  8*BUFLEN_BYTES  squeezed bytes; byte i = bits [8i+7:8i].
- buflen  input  16  number of valid bytes in linear_buf_in.
- ctr_in  input  9  index of the first coefficient to fill.
- linear_coeffs_out  output  32*N  coefficient j = bits [32j+31:32j], zero-extended 23-bit value.
- ctr_out  output  9  number of filled coefficients.
- rts  output  1  one-cycle done pulse.

Behaviour:
- Reset (asynchronous, any state, including mid-scan): state goes to IDLE; rts=0, ctr_out=0, all coefficients 0, internal position 0. The next start after reset must behave as a fresh call.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on rtr=1 at a clock edge:
  - capture linear_buf_in into an internal buffer.
  - capture len = min(buflen, BUFLEN_BYTES).
  - set ctr = min(ctr_in, N) and pos = 0.
  - go to SCAN.
- After capture, changes on the inputs have no effect. rtr while not in IDLE is ignored.
- SCAN, each cycle:
  - If ctr == N or pos+3 > len: go to DONE; no triple is processed.
  - Otherwise: t = (b[pos] | b[pos+1]<<8 | b[pos+2]<<16) & 0x7FFFFF.
  - If t < Q: coeff[ctr] <= t and ctr <= ctr+1.
  - pos <= pos+3.
- DONE: rts=1 for exactly this cycle, ctr_out holds the final ctr; next state is IDLE.
- Latency: with k triples processed, rts is high in the (k+2)th cycle after the rtr capture edge. The capture edge enters SCAN, then k processing cycles, one terminating SCAN cycle, then DONE.
- ctr_out tracks ctr live during SCAN. It is final when rts is high and holds until the next capture.
- linear_coeffs_out is driven directly from the coefficient registers.
  - Entries below the captured ctr_in are never written during a call.
  - Entries at or above the final ctr keep their old values.
- Boundary conditions:
  - Trailing bytes (len mod 3) are ignored.
  - len < 3 gives zero triples.
  - ctr_in ≥ N gives zero triples and ctr_out = N.
  - Comparison is unsigned 23-bit against Q; bit 23 of the third byte is always discarded.
- Arithmetic widths:
  - pos: 16 bits, compared as pos+3 ≤ len in 17 bits.
  - ctr: 9 bits.
- Indexing: byte selection is a 3-byte mux on pos.
- One triple per cycle; no stalls.

Test Plan:
- All-zero buffer, buflen=840, ctr_in=0 -> coeffs 0..255 = 0, ctr_out=256, rts 258 cycles after capture, single-cycle pulse.
- All-0xFF buffer, buflen=840, ctr_in=0 -> every candidate 0x7FFFFF rejected, ctr_out=0, rts 282 cycles after capture.
- Threshold check: triples (00 E0 7F), (01 E0 7F), (00 00 80), (12 34 56), buflen=12 -> coeff[0]=0x7FE000, coeff[1]=0x000000, coeff[2]=0x563412, ctr_out=3.
- Refill: first call fills 250 coefficients; second call with ctr_in=250 and a zero buffer -> coeff[250..255]=0, coeffs 0..249 unchanged, ctr_out=256, rts 8 cycles after capture.
- buflen=5 with bytes 01 00 00 FF FF -> one triple, coeff[0]=1, ctr_out=1.
- Assert reset 50 cycles into a scan -> rts=0, ctr_out=0, coeffs cleared immediately; rtr held during SCAN ignored; a fresh call afterwards runs correctly.
